fetch_stage: RTL and testbench

- Instruction fetch and instruction-register stage of the MIPS datapath. It owns the PC, issues requests to instruction memory, and holds the current instruction for decode.
- It slices the 16-bit immediate out for the downstream sign extender. It consumes the 32-bit sign-extended immediate back to form branch targets.
- Resolves jump, jr and branch redirects, and buffers one returned word when decode stalls.

---
 rtl/fetch_pkg.sv | 31 +++
 rtl/next_pc_calc.sv | 45 ++++
 rtl/fetch_stage.sv | 156 +++++++++++++++
 tb/tb_fetch_stage.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared definitions for the instruction fetch stage: the fetch state
// encoding, the bit positions of the instruction fields that are handed to
// decode, and the width of one instruction in bytes.
package fetch_pkg;

  // IDLE  : one quiet cycle after reset before the first request
  // FETCH : request outstanding at pc
  // FULL  : instr and skid both hold words, request paused
  // DRAIN : redirect seen while a request was in flight; wait it out
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int JIDX_MSB  = 25;
  localparam int JIDX_LSB  = 0;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc
// Combinational redirect target for the instruction currently held in the
// instruction register. Priority is jr, then jump, then branch.
// Ports:
//   instr_pc    PC of the current instruction
//   instr_index instr[25:0], the J-type word index
//   imm_ext     sign-extended 16-bit immediate
//   jr_target   register-sourced jump address
//   sel_jr / sel_jump / sel_branch  redirect kind selects
//   target      chosen redirect address (pc4 when nothing is selected)
module next_pc_calc
  import fetch_pkg::*;
(
  input  logic [31:0] instr_pc,
  input  logic [25:0] instr_index,
  input  logic [31:0] imm_ext,
  input  logic [31:0] jr_target,
  input  logic        sel_jr,
  input  logic        sel_jump,
  input  logic        sel_branch,
  output logic [31:0] target
);

  logic [31:0] pc4;
  logic [31:0] branch_target;
  logic [31:0] jump_target;

  // All arithmetic wraps modulo 2^32; there is no overflow detection.
  assign pc4           = instr_pc + INSTR_BYTES;
  assign branch_target = pc4 + (imm_ext << 2);
  assign jump_target   = {pc4[31:28], instr_index, 2'b00};

  // Priority mux: jr beats jump beats branch.
  always_comb begin
    target = pc4;
    if (sel_jr) begin
      target = jr_target;
    end else if (sel_jump) begin
      target = jump_target;
    end else if (sel_branch) begin
      target = branch_target;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
// Owns the PC, issues instruction memory requests, holds the current
// instruction for decode, buffers one extra word when decode stalls and
// applies jump / jr / branch redirects.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   imem_req/imem_addr  fetch request and word address (held until ready)
//   imem_ready/rdata    request completion and returned word
//   stall               decode cannot take the current instruction
//   branch_taken/jump/jr/jr_target/imm_ext  redirect information
//   instr/instr_pc/instr_valid  instruction register for decode
//   imm/rs/rt/rd        field slices of instr
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic [31:0] imm_ext,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic [15:0] imm,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic [31:0]  skid;
  logic [31:0]  skid_pc;
  logic [31:0]  pend;
  logic [31:0]  target;
  logic         accept;
  logic         redirect;

  // Redirect inputs only matter when decode actually takes the instruction.
  assign accept   = instr_valid & ~stall;
  assign redirect = accept & (jr | jump | branch_taken);
  assign pc_plus4 = pc + INSTR_BYTES;

  assign imm = instr[IMM_MSB:IMM_LSB];
  assign rs  = instr[RS_MSB:RS_LSB];
  assign rt  = instr[RT_MSB:RT_LSB];
  assign rd  = instr[RD_MSB:RD_LSB];

  next_pc_calc u_next_pc_calc (
    .instr_pc    (instr_pc),
    .instr_index (instr[JIDX_MSB:JIDX_LSB]),
    .imm_ext     (imm_ext),
    .jr_target   (jr_target),
    .sel_jr      (jr),
    .sel_jump    (jump),
    .sel_branch  (branch_taken),
    .target      (target)
  );

  // Fetch control. imem_req and imem_addr are registered alongside the state
  // so the address only moves when the outstanding request completes or a
  // new request is started. A redirect that arrives while a request is still
  // in flight parks its target in pend and lets the memory finish (DRAIN),
  // because the address must stay stable until imem_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      skid        <= '0;
      skid_pc     <= '0;
      pend        <= '0;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          state     <= FETCH;
          imem_req  <= 1'b1;
          imem_addr <= pc;
        end

        FETCH: begin
          if (redirect) begin
            instr_valid <= 1'b0;
            if (imem_ready) begin
              pc        <= target;
              imem_addr <= target;
            end else begin
              pend  <= target;
              state <= DRAIN;
            end
          end else if (imem_ready) begin
            pc        <= pc_plus4;
            imem_addr <= pc_plus4;
            if (!instr_valid || accept) begin
              instr       <= imem_rdata;
              instr_pc    <= pc;
              instr_valid <= 1'b1;
            end else begin
              // Decode is stalled on a live instruction: park the word.
              skid     <= imem_rdata;
              skid_pc  <= pc;
              imem_req <= 1'b0;
              state    <= FULL;
            end
          end else if (accept) begin
            instr_valid <= 1'b0;
          end
        end

        FULL: begin
          if (redirect) begin
            instr_valid <= 1'b0;
            pc          <= target;
            imem_addr   <= target;
            imem_req    <= 1'b1;
            state       <= FETCH;
          end else if (accept) begin
            instr       <= skid;
            instr_pc    <= skid_pc;
            instr_valid <= 1'b1;
            imem_addr   <= pc;
            imem_req    <= 1'b1;
            state       <= FETCH;
          end
        end

        DRAIN: begin
          if (imem_ready) begin
            pc        <= pend;
            imem_addr <= pend;
            state     <= FETCH;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
// Directed bench for fetch_stage. Every word that should reach decode is
// pushed to a scoreboard queue when it is driven from memory and popped when
// decode accepts it (instr_valid & !stall just before an edge).
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } sb_entry_t;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic        jump;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] imm_ext;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic [15:0] imm;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;

  int vectors;
  int miscompares;
  sb_entry_t sb[$];

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .branch_taken (branch_taken),
    .jump         (jump),
    .jr           (jr),
    .jr_target    (jr_target),
    .imm_ext      (imm_ext),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .imm          (imm),
    .rs           (rs),
    .rt           (rt),
    .rd           (rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison point: counts the vector and reports any miscompare.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drives every DUT input for the next clock edge.
  task automatic applyStimulus(input logic rdy, input logic [31:0] rdata,
                               input logic stl, input logic br,
                               input logic jmp, input logic jrr,
                               input logic [31:0] jtgt,
                               input logic [31:0] imx);
    imem_ready   = rdy;
    imem_rdata   = rdata;
    stall        = stl;
    branch_taken = br;
    jump         = jmp;
    jr           = jrr;
    jr_target    = jtgt;
    imm_ext      = imx;
  endtask

  // Retires an accepted instruction against the scoreboard, then advances
  // to 1 ns past the next rising edge where outputs are sampled.
  task automatic tick();
    sb_entry_t e;
    if (instr_valid && !stall) begin
      checkOutput("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checkOutput("accepted_instr", instr, e.word);
        checkOutput("accepted_pc", instr_pc, e.pc);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] word, input logic [31:0] pc);
    sb_entry_t e;
    e.word = word;
    e.pc   = pc;
    sb.push_back(e);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", instr_valid, 1'b0);
    checkOutput("rst_req", imem_req, 1'b0);
    checkOutput("rst_addr", imem_addr, RESET_PC);
    checkOutput("rst_instr", instr, 32'h0);

    // First request one cycle after release
    rst_n = 1'b1;
    tick();
    checkOutput("first_req", imem_req, 1'b1);
    checkOutput("first_addr", imem_addr, 32'h0040_0000);

    // First word loads; field slices
    applyStimulus(1'b1, 32'h2008_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    push(32'h2008_FFFF, 32'h0040_0000);
    tick();
    checkOutput("first_valid", instr_valid, 1'b1);
    checkOutput("first_imm", imm, 16'hFFFF);
    checkOutput("first_rt", rt, 5'd8);
    checkOutput("first_rs", rs, 5'd0);
    checkOutput("first_rd", rd, 5'd31);
    checkOutput("second_addr", imem_addr, 32'h0040_0004);

    // Back-to-back zero-wait fetches, one instruction per cycle
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 32'h1000_0000 | k, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      push(32'h1000_0000 | k, RESET_PC + 32'(4 * k));
      tick();
      checkOutput("stream_pc", instr_pc, RESET_PC + 32'(4 * k));
      checkOutput("stream_addr", imem_addr, RESET_PC + 32'(4 * k + 4));
    end

    // Backward branch from 0x00400010 with imm_ext = -4, memory word dropped
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC);
    tick();
    checkOutput("branch_addr", imem_addr, 32'h0040_0004);
    checkOutput("branch_valid", instr_valid, 1'b0);

    // Load a J instruction, then jr to 0xF0000000
    applyStimulus(1'b1, 32'h0800_0010, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    push(32'h0800_0010, 32'h0040_0004);
    tick();
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b1, 32'hF000_0000, 32'h0);
    tick();
    checkOutput("jr_addr", imem_addr, 32'hF000_0000);

    // Jump from instr_pc 0xF0000000 with index 0x10
    applyStimulus(1'b1, 32'h0800_0010, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    push(32'h0800_0010, 32'hF000_0000);
    tick();
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("jump_addr", imem_addr, 32'hF000_0040);

    // All three redirect bits: jr wins
    applyStimulus(1'b1, 32'h0800_0010, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    push(32'h0800_0010, 32'hF000_0040);
    tick();
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_1234, 32'h0000_0100);
    tick();
    checkOutput("prio_addr", imem_addr, 32'h0000_1234);

    // Skid: stall while a word returns
    applyStimulus(1'b1, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    push(32'h1111_1111, 32'h0000_1234);
    tick();
    applyStimulus(1'b1, 32'hAAAA_0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    push(32'hAAAA_0000, 32'h0000_1238);
    tick();
    checkOutput("full_req", imem_req, 1'b0);
    checkOutput("full_instr", instr, 32'h1111_1111);
    // Redirect inputs are ignored while stalled
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("full_hold_req", imem_req, 1'b0);
    checkOutput("full_hold_instr", instr, 32'h1111_1111);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("skid_instr", instr, 32'hAAAA_0000);
    checkOutput("skid_pc", instr_pc, 32'h0000_1238);
    checkOutput("skid_req", imem_req, 1'b1);
    checkOutput("skid_addr", imem_addr, 32'h0000_123C);

    // DRAIN: branch from 0x1238 (+0x10 words) while memory is not ready
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0010);
    tick();
    checkOutput("drain_valid", instr_valid, 1'b0);
    for (int c = 0; c < 3; c++) begin
      checkOutput("drain_req", imem_req, 1'b1);
      checkOutput("drain_addr", imem_addr, 32'h0000_123C);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      if (c == 2) imem_ready = 1'b1;
      imem_rdata = 32'hBBBB_BBBB;
      tick();
    end
    checkOutput("drain_target", imem_addr, 32'h0000_127C);
    checkOutput("drain_dropped", instr_valid, 1'b0);

    // Async reset in the middle of DRAIN
    applyStimulus(1'b1, 32'h2222_2222, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    push(32'h2222_2222, 32'h0000_127C);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_5000, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("pre_rst_req", imem_req, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", instr_valid, 1'b0);
    checkOutput("arst_req", imem_req, 1'b0);
    checkOutput("arst_addr", imem_addr, RESET_PC);
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
